prio_encoder: RTL and testbench



---
 rtl/prio_encoder.sv | 62 ++++++
 tb/tb_prio_encoder.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/prio_encoder.sv
// Registered priority encoder: index of the highest-priority set bit of a 2**CODE_WIDTH-bit vector.
// Optional registered one-hot output of the winner when PRIO_ENC_ONEHOT_EN is defined.
module prio_encoder #(
    parameter int CODE_WIDTH = 2,
    parameter bit LSB_PRIO   = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [2**CODE_WIDTH-1:0]   data,
    output logic [CODE_WIDTH-1:0]      code,
    output logic                       valid
`ifdef PRIO_ENC_ONEHOT_EN
    ,
    output logic [2**CODE_WIDTH-1:0]   onehot
`endif
);

    localparam int DATA_W = 2**CODE_WIDTH;

    if (CODE_WIDTH < 1 || CODE_WIDTH > 6) begin : g_bad_width
        $error("prio_encoder: CODE_WIDTH must be in 1..6");
    end

    logic [CODE_WIDTH-1:0] code_next;
    logic                  valid_next;

    // Scan toward the winning end so the last hit assigned is the priority winner.
    always_comb begin
        code_next = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (LSB_PRIO) begin
                if (data[DATA_W-1-i]) code_next = CODE_WIDTH'(DATA_W-1-i);
            end else begin
                if (data[i]) code_next = CODE_WIDTH'(i);
            end
        end
    end

    assign valid_next = |data;

`ifdef PRIO_ENC_ONEHOT_EN
    logic [DATA_W-1:0] onehot_next;

    assign onehot_next = valid_next ? (DATA_W'(1) << code_next) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) onehot <= '0;
        else     onehot <= onehot_next;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code  <= '0;
            valid <= 1'b0;
        end else begin
            code  <= code_next;
            valid <= valid_next;
        end
    end

endmodule

// File: tb/tb_prio_encoder.sv
// Directed bench for prio_encoder: CODE_WIDTH 1/2/3 MSB-priority and CODE_WIDTH 3 LSB-priority instances.
module tb_prio_encoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0] d1 = '0;
    logic [3:0] d2 = '0;
    logic [7:0] d3 = '0;
    logic [7:0] dl = '0;
    logic       c1;
    logic [1:0] c2;
    logic [2:0] c3, cl;
    logic       v1, v2, v3, vl;
`ifdef PRIO_ENC_ONEHOT_EN
    logic [1:0] o1;
    logic [3:0] o2;
    logic [7:0] o3, ol;
`endif

    int n_vec = 0;
    int n_err = 0;

    prio_encoder #(.CODE_WIDTH(1), .LSB_PRIO(1'b0)) u_cw1 (
        .clk(clk), .rst(rst), .data(d1), .code(c1), .valid(v1)
`ifdef PRIO_ENC_ONEHOT_EN
        , .onehot(o1)
`endif
    );
    prio_encoder #(.CODE_WIDTH(2), .LSB_PRIO(1'b0)) u_cw2 (
        .clk(clk), .rst(rst), .data(d2), .code(c2), .valid(v2)
`ifdef PRIO_ENC_ONEHOT_EN
        , .onehot(o2)
`endif
    );
    prio_encoder #(.CODE_WIDTH(3), .LSB_PRIO(1'b0)) u_cw3 (
        .clk(clk), .rst(rst), .data(d3), .code(c3), .valid(v3)
`ifdef PRIO_ENC_ONEHOT_EN
        , .onehot(o3)
`endif
    );
    prio_encoder #(.CODE_WIDTH(3), .LSB_PRIO(1'b1)) u_lsb (
        .clk(clk), .rst(rst), .data(dl), .code(cl), .valid(vl)
`ifdef PRIO_ENC_ONEHOT_EN
        , .onehot(ol)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one capture edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: highest set index of the low w bits, 0 when empty.
    function automatic int ref_msb(input logic [63:0] v, input int w);
        int r = 0;
        for (int i = w - 1; i >= 0; i--)
            if (v[i]) return i;
        return r;
    endfunction

    initial begin
        // Reset state before any clock edge
        #2;
        chk("rst0_code", c3, 0);
        chk("rst0_valid", v3, 0);
        chk("rst0_lsb_valid", vl, 0);
        tick();
        @(negedge clk);
        rst = 1'b0;

        // CODE_WIDTH=1 corner table
        d1 = 2'b01; tick(); chk("cw1_01_code", c1, 0); chk("cw1_01_valid", v1, 1);
        d1 = 2'b10; tick(); chk("cw1_10_code", c1, 1); chk("cw1_10_valid", v1, 1);
        d1 = 2'b11; tick(); chk("cw1_11_code", c1, 1);
        d1 = 2'b00; tick(); chk("cw1_00_code", c1, 0); chk("cw1_00_valid", v1, 0);

        // CODE_WIDTH=2 hand sequence 0,1,2,3
        d2 = 4'd0; tick(); chk("cw2_s0_code", c2, 0); chk("cw2_s0_valid", v2, 0);
        d2 = 4'd1; tick(); chk("cw2_s1_code", c2, 0); chk("cw2_s1_valid", v2, 1);
        d2 = 4'd2; tick(); chk("cw2_s2_code", c2, 1); chk("cw2_s2_valid", v2, 1);
        d2 = 4'd3; tick(); chk("cw2_s3_code", c2, 1); chk("cw2_s3_valid", v2, 1);

        // LSB priority
        dl = 8'b1010_1000; tick(); chk("lsb_a8_code", cl, 3); chk("lsb_a8_valid", vl, 1);
        dl = 8'b1000_0000; tick(); chk("lsb_80_code", cl, 7);
        dl = 8'hFF;        tick(); chk("lsb_ff_code", cl, 0);
        dl = 8'h00;        tick(); chk("lsb_00_code", cl, 0); chk("lsb_00_valid", vl, 0);

        // Back-to-back changes, one cycle latency each
        d3 = 8'h01; tick(); chk("b2b_01_code", c3, 0); chk("b2b_01_valid", v3, 1);
        d3 = 8'h80; tick(); chk("b2b_80_code", c3, 7); chk("b2b_80_valid", v3, 1);
        d3 = 8'h00; tick(); chk("b2b_00_code", c3, 0); chk("b2b_00_valid", v3, 0);
        d3 = 8'h2C; tick(); chk("cw3_2c_code", c3, 5);

`ifdef PRIO_ENC_ONEHOT_EN
        d2 = 4'b0110; tick(); chk("oh_0110_onehot", o2, 4'b0100); chk("oh_0110_code", c2, 2);
        d2 = 4'b0000; tick(); chk("oh_0000_onehot", o2, 4'b0000);
        dl = 8'b1010_1000; tick(); chk("oh_lsb_onehot", ol, 8'b0000_1000);
`endif

        // Asynchronous reset mid-run with all ones applied
        d3 = 8'hFF; tick(); chk("pre_rst_code", c3, 7);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_code", c3, 0);
        chk("async_rst_valid", v3, 0);
        d3 = 'x;
        tick();
        chk("rst_x_code", c3, 0);
        chk("rst_x_valid", v3, 0);
`ifdef PRIO_ENC_ONEHOT_EN
        chk("rst_x_onehot", o3, 0);
`endif
        d3 = 8'hFF;
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("post_rst_code", c3, 7);
        chk("post_rst_valid", v3, 1);

        // Counting sweep with wrap-around on all three MSB instances
        for (int n = 0; n < 260; n++) begin
            d1 = 2'(n);
            d2 = 4'(n);
            d3 = 8'(n);
            tick();
            chk("sweep_cw1_code", c1, ref_msb(64'(d1), 2));
            chk("sweep_cw2_code", c2, ref_msb(64'(d2), 4));
            chk("sweep_cw3_code", c3, ref_msb(64'(d3), 8));
            chk("sweep_cw3_valid", v3, (d3 != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
